// File: rtl/spdif_pkg.sv
// +------------------------------------------------------------------+
// | Module      : spdif_pkg                                          |
// | Description : Shared types, slot constants and preamble matcher  |
// |               for the S/PDIF biphase-mark receiver.              |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
`default_nettype none

package spdif_pkg;

   // Receiver framing state
   typedef enum logic [1:0] {
      ST_HUNT = 2'd0,
      ST_PRE  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   // Preamble kinds; B marks the first subframe of a channel-status block
   typedef enum logic [1:0] {
      PRE_B    = 2'd0,
      PRE_M    = 2'd1,
      PRE_W    = 2'd2,
      PRE_NONE = 2'd3
   } pre_t;

   // Edge-to-edge interval class in units of biphase half-cells
   typedef enum logic [1:0] {
      CLS_S1  = 2'd0,
      CLS_S2  = 2'd1,
      CLS_S3  = 2'd2,
      CLS_ERR = 2'd3
   } cls_t;

   localparam int SLOT_AUDIO_LO = 4;
   localparam int SLOT_AUDIO_HI = 27;
   localparam int SLOT_PARITY   = 31;

   // Slots 4..31 are shifted in; slots 4..27 carry the audio word
   localparam int SUBFRAME_BITS = SLOT_PARITY - SLOT_AUDIO_LO + 1;
   localparam int SAMPLE_BITS   = SLOT_AUDIO_HI - SLOT_AUDIO_LO + 1;

   // The three intervals following the leading S3 identify the preamble
   function automatic pre_t match_preamble(input cls_t c1, input cls_t c2, input cls_t c3);
      pre_t p;
      p = PRE_NONE;
      if (c1 == CLS_S1 && c2 == CLS_S1 && c3 == CLS_S3)
         p = PRE_B;
      else if (c1 == CLS_S3 && c2 == CLS_S1 && c3 == CLS_S1)
         p = PRE_M;
      else if (c1 == CLS_S2 && c2 == CLS_S1 && c3 == CLS_S2)
         p = PRE_W;
      return p;
   endfunction

endpackage

`default_nettype wire

// File: rtl/spdif_interval.sv
// +------------------------------------------------------------------+
// | Module      : spdif_interval                                     |
// | Description : Synchronises the raw line, detects both edges and  |
// |               classifies each edge-to-edge interval.             |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
`default_nettype none

module spdif_interval
   import spdif_pkg::*;
#(
   parameter int CLKS_PER_UI = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic spdif_async,
   output logic iv_valid,
   output cls_t iv_class
);

   localparam int CNT_MAX = 4 * CLKS_PER_UI;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   // Doubled length so the half-UI thresholds stay integral
   localparam int LEN_W   = CNT_W + 1;

   logic             sync_a;
   logic             sync_b;
   logic             line_d;
   logic             started;
   logic             edge_det;
   logic [CNT_W-1:0] cnt;
   logic [LEN_W-1:0] len2;

   // Two-flop synchroniser plus one history flop for the edge compare
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
         line_d <= 1'b0;
      end else begin
         sync_a <= spdif_async;
         sync_b <= sync_a;
         line_d <= sync_b;
      end
   end

   assign edge_det = sync_b ^ line_d;

   // Interval timer: restarts at 1 on every edge, saturates on a dead line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         started <= 1'b0;
      end else if (edge_det) begin
         cnt     <= CNT_W'(1);
         started <= 1'b1;
      end else if (cnt != CNT_W'(CNT_MAX)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign len2 = {cnt, 1'b0};

   // The first edge after reset has no reference point, so it only arms timing
   assign iv_valid = edge_det & started;

   // Classify the interval ending at this edge against half-UI boundaries
   always_comb begin
      iv_class = CLS_ERR;
      if (len2 < LEN_W'(CLKS_PER_UI))
         iv_class = CLS_ERR;
      else if (len2 < LEN_W'(3 * CLKS_PER_UI))
         iv_class = CLS_S1;
      else if (len2 < LEN_W'(5 * CLKS_PER_UI))
         iv_class = CLS_S2;
      else if (len2 < LEN_W'(7 * CLKS_PER_UI))
         iv_class = CLS_S3;
      else
         iv_class = CLS_ERR;
   end

endmodule

`default_nettype wire

// File: rtl/spdif_in.sv
// +------------------------------------------------------------------+
// | Module      : spdif_in                                           |
// | Description : S/PDIF biphase-mark receiver. Frames subframes on  |
// |               preambles, decodes 24-bit samples, checks parity   |
// |               and presents left/right pairs with a strobe.       |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
`default_nettype none

module spdif_in
   import spdif_pkg::*;
#(
   parameter int CLKS_PER_UI = 16,
   parameter int LOCK_FRAMES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               spdif_async,
   output logic signed [23:0] left,
   output logic signed [23:0] right,
   output logic               data_valid,
   output logic               block_start,
   output logic               parity_error,
   output logic               locked
);

   localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);

   logic                     iv_valid;
   cls_t                     iv_class;

   state_t                   state;
   logic [1:0]               pre_idx;
   cls_t                     pre_c1;
   cls_t                     pre_c2;
   pre_t                     pre_kind;
   pre_t                     pre_seen;
   logic [4:0]               slot;
   logic                     half_one;
   logic [SUBFRAME_BITS-1:0] shreg;
   logic [SUBFRAME_BITS-1:0] sh_next;
   logic [SAMPLE_BITS-1:0]   hold;
   logic                     left_pending;
   logic                     is_block;
   logic [GOOD_W-1:0]        good_cnt;

   logic                     bit_done;
   logic                     bit_val;
   logic                     data_abort;
   logic                     frame_end;
   logic                     parity_ok;
   logic                     to_hunt;

   spdif_interval #(
      .CLKS_PER_UI (CLKS_PER_UI)
   ) u_interval (
      .clk         (clk),
      .rst         (rst),
      .spdif_async (spdif_async),
      .iv_valid    (iv_valid),
      .iv_class    (iv_class)
   );

   assign pre_seen  = match_preamble(pre_c1, pre_c2, iv_class);
   assign sh_next   = {bit_val, shreg[SUBFRAME_BITS-1:1]};
   assign parity_ok = ~(^sh_next);
   assign frame_end = bit_done && (slot == 5'(SLOT_PARITY));

   // Biphase bit decode and every condition that drops framing back to HUNT
   always_comb begin
      bit_done   = 1'b0;
      bit_val    = 1'b0;
      data_abort = 1'b0;
      to_hunt    = 1'b0;
      if (iv_valid && state == ST_DATA) begin
         if (half_one) begin
            // Second half of a '1' cell must be another short interval
            if (iv_class == CLS_S1) begin
               bit_done = 1'b1;
               bit_val  = 1'b1;
            end else begin
               data_abort = 1'b1;
            end
         end else begin
            case (iv_class)
               CLS_S2:  bit_done   = 1'b1;
               CLS_S1:  bit_done   = 1'b0;
               default: data_abort = 1'b1;
            endcase
         end
      end
      if (iv_valid) begin
         case (state)
            ST_PRE: begin
               if (pre_idx == 2'd0)
                  to_hunt = (iv_class != CLS_S3);
               else if (pre_idx == 2'd3)
                  to_hunt = (pre_seen == PRE_NONE);
               else
                  to_hunt = (iv_class == CLS_ERR);
            end
            ST_DATA: to_hunt = data_abort || (frame_end && !parity_ok);
            default: to_hunt = 1'b0;
         endcase
      end
   end

   // Framing FSM with registered sample, strobe and lock outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_HUNT;
         pre_idx      <= 2'd0;
         pre_c1       <= CLS_S1;
         pre_c2       <= CLS_S1;
         pre_kind     <= PRE_NONE;
         slot         <= 5'd0;
         half_one     <= 1'b0;
         shreg        <= '0;
         hold         <= '0;
         left_pending <= 1'b0;
         is_block     <= 1'b0;
         good_cnt     <= '0;
         left         <= '0;
         right        <= '0;
         data_valid   <= 1'b0;
         block_start  <= 1'b0;
         parity_error <= 1'b0;
         locked       <= 1'b0;
      end else begin
         data_valid   <= 1'b0;
         block_start  <= 1'b0;
         parity_error <= 1'b0;

         // A malformed interval anywhere means the stream is not trustworthy
         if (iv_valid && iv_class == CLS_ERR)
            locked <= 1'b0;

         case (state)
            ST_HUNT: begin
               if (iv_valid && iv_class == CLS_S3) begin
                  state   <= ST_PRE;
                  pre_idx <= 2'd1;
               end
            end

            ST_PRE: begin
               if (iv_valid) begin
                  case (pre_idx)
                     2'd0: pre_idx <= 2'd1;
                     2'd1: begin
                        pre_c1  <= iv_class;
                        pre_idx <= 2'd2;
                     end
                     2'd2: begin
                        pre_c2  <= iv_class;
                        pre_idx <= 2'd3;
                     end
                     default: begin
                        pre_kind <= pre_seen;
                        state    <= ST_DATA;
                        slot     <= 5'(SLOT_AUDIO_LO);
                        half_one <= 1'b0;
                     end
                  endcase
               end
            end

            ST_DATA: begin
               if (iv_valid && !half_one && iv_class == CLS_S1)
                  half_one <= 1'b1;
               if (bit_done) begin
                  half_one <= 1'b0;
                  shreg    <= sh_next;
                  slot     <= slot + 5'd1;
                  if (frame_end) begin
                     if (parity_ok) begin
                        // Next interval must be the leading S3 of the next preamble
                        state   <= ST_PRE;
                        pre_idx <= 2'd0;
                        if (good_cnt != GOOD_W'(LOCK_FRAMES))
                           good_cnt <= good_cnt + 1'b1;
                        if (good_cnt >= GOOD_W'(LOCK_FRAMES - 1))
                           locked <= 1'b1;
                        if (pre_kind != PRE_W) begin
                           hold         <= sh_next[SAMPLE_BITS-1:0];
                           left_pending <= 1'b1;
                           is_block     <= (pre_kind == PRE_B);
                        end else if (left_pending) begin
                           left         <= hold;
                           right        <= sh_next[SAMPLE_BITS-1:0];
                           data_valid   <= 1'b1;
                           block_start  <= is_block;
                           left_pending <= 1'b0;
                        end
                     end else begin
                        parity_error <= 1'b1;
                     end
                  end
               end
            end

            default: state <= ST_HUNT;
         endcase

         // Losing framing discards any half-built pair and restarts lock counting
         if (to_hunt) begin
            state        <= ST_HUNT;
            locked       <= 1'b0;
            good_cnt     <= '0;
            left_pending <= 1'b0;
            half_one     <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_spdif_in.sv
// +------------------------------------------------------------------+
// | Module      : tb_spdif_in                                        |
// | Description : Self-checking bench for spdif_in. A biphase line   |
// |               model drives subframes; expected pairs are queued  |
// |               and popped on each data_valid strobe.              |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
`default_nettype none

module tb_spdif_in;

   localparam int UI  = 16;
   localparam int P_B = 0;
   localparam int P_M = 1;
   localparam int P_W = 2;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               spdif_async = 1'b0;
   logic signed [23:0] left;
   logic signed [23:0] right;
   logic               data_valid;
   logic               block_start;
   logic               parity_error;
   logic               locked;

   int     n_tests = 0;
   int     n_fail  = 0;
   int     par_cnt = 0;
   logic   par_d   = 1'b0;
   longint cyc     = 0;
   bit     jit     = 1'b0;

   typedef struct {
      logic signed [23:0] l;
      logic signed [23:0] r;
      logic               blk;
   } exp_t;

   typedef struct {
      longint             due;
      logic               lk;
      logic               lr;
      logic signed [23:0] l;
      logic signed [23:0] r;
   } chk_t;

   exp_t exp_q[$];
   chk_t chk_q[$];
   exp_t e_cur;
   chk_t c_cur;

   spdif_in #(
      .CLKS_PER_UI (UI),
      .LOCK_FRAMES (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .spdif_async  (spdif_async),
      .left         (left),
      .right        (right),
      .data_valid   (data_valid),
      .block_start  (block_start),
      .parity_error (parity_error),
      .locked       (locked)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   // Strobe scoreboard, parity pulse width and deferred lock/hold checks
   always @(negedge clk) begin
      if (data_valid) begin
         check_eq("dv_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            e_cur = exp_q.pop_front();
            check_eq("dv_left", left, e_cur.l);
            check_eq("dv_right", right, e_cur.r);
            check_eq("dv_block_start", block_start, e_cur.blk);
         end
      end
      if (parity_error) begin
         par_cnt++;
         check_eq("perr_one_cycle", par_d, 0);
      end
      par_d = parity_error;
      while (chk_q.size() > 0 && chk_q[0].due <= cyc) begin
         c_cur = chk_q.pop_front();
         check_eq("locked", locked, c_cur.lk);
         if (c_cur.lr) begin
            check_eq("hold_left", left, c_cur.l);
            check_eq("hold_right", right, c_cur.r);
         end
      end
   end

   // Checks a few cycles after the current line edge has been decoded
   task automatic lock_chk(input logic lk, input logic lr, input logic signed [23:0] l, input logic signed [23:0] r);
      chk_t c;
      c.due = cyc + 5;
      c.lk  = lk;
      c.lr  = lr;
      c.l   = l;
      c.r   = r;
      chk_q.push_back(c);
   endtask

   task automatic toggle_after(input int n);
      repeat (n) @(posedge clk);
      #1 spdif_async = ~spdif_async;
   endtask

   // Each edge lands up to 5 cycles either side of where the previous edge puts it
   task automatic send_half(input int h);
      int n;
      n = h * UI;
      if (jit)
         n = n + int'($urandom_range(10)) - 5;
      toggle_after(n);
   endtask

   // Drives slots first_slot..last_slot of one subframe (slot 0 includes the preamble)
   task automatic send_sf(input int pre, input logic [23:0] smp, input bit flip_par,
                          input int first_slot, input int last_slot);
      logic [27:0] w;
      int          pa[4];
      w        = '0;
      w[23:0]  = smp;
      w[27]    = (^w[26:0]) ^ flip_par;
      if (first_slot == 0) begin
         case (pre)
            P_B:     pa = '{3, 1, 1, 3};
            P_M:     pa = '{3, 3, 1, 1};
            default: pa = '{3, 2, 1, 2};
         endcase
         for (int i = 0; i < 4; i++) send_half(pa[i]);
      end
      for (int s = (first_slot < 4 ? 4 : first_slot); s <= last_slot; s++) begin
         if (w[s-4]) begin
            send_half(1);
            send_half(1);
         end else begin
            send_half(2);
         end
      end
   endtask

   task automatic push_exp(input logic [23:0] l, input logic [23:0] r, input logic blk);
      exp_t e;
      e.l   = l;
      e.r   = r;
      e.blk = blk;
      exp_q.push_back(e);
   endtask

   // Idle gap then one edge: any decoder state falls back to HUNT
   task automatic start_seg();
      toggle_after(100);
   endtask

   task automatic bw_scenario();
      start_seg();
      push_exp(24'h123456, 24'hFEDCBA, 1'b1);
      send_sf(P_B, 24'h123456, 0, 0, 31);
      lock_chk(1'b0, 1'b0, '0, '0);
      send_sf(P_W, 24'hFEDCBA, 0, 0, 31);
      lock_chk(1'b1, 1'b1, 24'sh123456, 24'shFEDCBA);
      push_exp(24'h123456, 24'hFEDCBA, 1'b1);
      send_sf(P_B, 24'h123456, 0, 0, 31);
      send_sf(P_W, 24'hFEDCBA, 0, 0, 31);
      lock_chk(1'b1, 1'b1, 24'sh123456, 24'shFEDCBA);
   endtask

   initial begin
      repeat (4) @(posedge clk);
      #1;
      check_eq("rst_left", left, 0);
      check_eq("rst_right", right, 0);
      check_eq("rst_data_valid", data_valid, 0);
      check_eq("rst_block_start", block_start, 0);
      check_eq("rst_parity_error", parity_error, 0);
      check_eq("rst_locked", locked, 0);
      rst = 1'b0;

      // B/W frames, block start flagged, lock on the second subframe
      bw_scenario();

      // M/W frame with full-scale signed extremes
      start_seg();
      push_exp(24'h800000, 24'h7FFFFF, 1'b0);
      send_sf(P_M, 24'h800000, 0, 0, 31);
      send_sf(P_W, 24'h7FFFFF, 0, 0, 31);
      lock_chk(1'b1, 1'b1, 24'sh800000, 24'sh7FFFFF);
      repeat (20) @(posedge clk);
      #1;
      check_eq("left_neg_full", left, -8388608);
      check_eq("right_pos_full", right, 8388607);

      // Parity failure in a W subframe, then re-lock
      start_seg();
      push_exp(24'h123456, 24'hFEDCBA, 1'b1);
      send_sf(P_B, 24'h123456, 0, 0, 31);
      send_sf(P_W, 24'hFEDCBA, 0, 0, 31);
      send_sf(P_B, 24'h0A5A5A, 0, 0, 31);
      send_sf(P_W, 24'h0F0F0F, 1, 0, 31);
      lock_chk(1'b0, 1'b1, 24'sh123456, 24'shFEDCBA);
      push_exp(24'h3C3C3C, 24'hC3C3C3, 1'b1);
      send_sf(P_B, 24'h3C3C3C, 0, 0, 31);
      lock_chk(1'b0, 1'b1, 24'sh123456, 24'shFEDCBA);
      send_sf(P_W, 24'hC3C3C3, 0, 0, 31);
      lock_chk(1'b1, 1'b1, 24'sh3C3C3C, 24'shC3C3C3);

      // Jittered edges, then a 60-cycle hole in the middle of a subframe
      jit = 1'b1;
      start_seg();
      for (int k = 0; k < 2; k++) begin
         push_exp(24'h55AA33, 24'h0000FF, 1'b1);
         send_sf(P_B, 24'h55AA33, 0, 0, 31);
         send_sf(P_W, 24'h0000FF, 0, 0, 31);
      end
      lock_chk(1'b1, 1'b1, 24'sh55AA33, 24'sh0000FF);
      send_sf(P_B, 24'h13579B, 0, 0, 12);
      toggle_after(60);
      lock_chk(1'b0, 1'b1, 24'sh55AA33, 24'sh0000FF);
      jit = 1'b0;

      // Stream joined mid-subframe: only the first whole M/W pair is reported
      start_seg();
      send_sf(P_W, 24'h777777, 0, 10, 31);
      push_exp(24'h800000, 24'h7FFFFF, 1'b0);
      send_sf(P_M, 24'h800000, 0, 0, 31);
      send_sf(P_W, 24'h7FFFFF, 0, 0, 31);
      lock_chk(1'b1, 1'b1, 24'sh800000, 24'sh7FFFFF);

      // Reset during slot 15 discards the partial B and the W that follows it
      send_sf(P_B, 24'h00F00F, 0, 0, 14);
      repeat (8) @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("midrst_left", left, 0);
      check_eq("midrst_right", right, 0);
      check_eq("midrst_locked", locked, 0);
      rst = 1'b0;
      send_sf(P_B, 24'h00F00F, 0, 15, 31);
      send_sf(P_W, 24'h777777, 0, 0, 31);
      lock_chk(1'b0, 1'b1, '0, '0);
      push_exp(24'hABCDEF, 24'h000001, 1'b1);
      send_sf(P_B, 24'hABCDEF, 0, 0, 31);
      lock_chk(1'b1, 1'b1, '0, '0);
      send_sf(P_W, 24'h000001, 0, 0, 31);
      lock_chk(1'b1, 1'b1, 24'shABCDEF, 24'sh000001);

      // Same B/W stream with the line starting from the opposite level
      if (spdif_async == 1'b0)
         toggle_after(100);
      bw_scenario();

      repeat (200) @(posedge clk);
      #1;
      check_eq("exp_queue_drained", exp_q.size(), 0);
      check_eq("chk_queue_drained", chk_q.size(), 0);
      check_eq("parity_error_count", par_cnt, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: got cycle %0d expected finish before 90000", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
